regfile_wr_arbiter: RTL

//  Shares the single register-file write port between two writeback sources:
//  A (load/memory return, preferred) and B (ALU/CSR result).

---
 rtl/regfile_wr_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/regfile_wr_arbiter.sv
// Two-source write-port arbiter for the register file: A (memory return) is preferred,
// B (ALU/CSR) is forced through after MAX_WAIT consecutive losses. One registered write per cycle.
module regfile_wr_arbiter #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              a_valid,
  input  logic [4:0]        a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [4:0]        b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [31:0]       wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_src,
  output logic              b_starved
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt;
  logic [3:0]        wait_next;
  logic              grant;
  logic [4:0]        grant_addr;
  logic [DATA_W-1:0] grant_data;
  logic [31:0]       addr_onehot;

  // Readies look only at valids, stall and the starvation counter, never at addr/data.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst && !stall) begin
      if (b_valid && (!a_valid || wait_cnt == MAX_CNT)) begin
        b_ready = 1'b1;
      end else if (a_valid) begin
        a_ready = 1'b1;
      end
    end
  end

  assign grant      = a_ready | b_ready;
  assign grant_addr = b_ready ? b_addr : a_addr;
  assign grant_data = b_ready ? b_data : a_data;

  // Bit 0 is left clear: x0 is hardwired zero and must never see a write enable.
  always_comb begin
    addr_onehot = '0;
    for (int i = 1; i < 32; i++) begin
      if (grant_addr == 5'(i)) begin
        addr_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    wait_next = wait_cnt;
    if (!b_valid || b_ready) begin
      wait_next = '0;
    end else if (wait_cnt != MAX_CNT) begin
      wait_next = wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en     <= '0;
      wr_data   <= '0;
      wr_src    <= 1'b0;
      wait_cnt  <= '0;
      b_starved <= 1'b0;
    end else begin
      wr_en     <= grant ? addr_onehot : '0;
      if (grant) begin
        wr_data <= grant_data;
        wr_src  <= b_ready;
      end
      wait_cnt  <= wait_next;
      b_starved <= (wait_next == MAX_CNT);
    end
  end

endmodule
